// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver with double-buffered frame input.
// Optional macro SEG_DIM_EN adds a 3-bit brightness port that PWM-trims the lit part of each slot.
module seg_scan_driver #(
  parameter int REFRESH_DIV  = 25000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
`ifdef SEG_DIM_EN
  input  logic [2:0]  brightness,
`endif
  output logic [7:0]  seg,
  output logic [3:0]  dig,
  output logic        frame_done
);

  localparam int          DRIVE_LEN  = REFRESH_DIV - BLANK_CYCLES;
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0] DRIVE_LAST = 16'(DRIVE_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, DRIVE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  dig_q, dig_d;
  logic        fd_q, fd_d;
  logic [31:0] active_q, pending_q;
  logic        pfull_q;
  logic [31:0] on_len;
  logic        commit, accept;

  // State register: outputs are registered from next-state values so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 16'd0;
      seg_q   <= 8'hFF;
      dig_q   <= 4'hF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = 2'd0;
          cnt_d   = 16'd0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = BLANK;
            cnt_d   = 16'd0;
            idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

`ifdef SEG_DIM_EN
  assign on_len = ((32'(brightness) + 32'd1) * 32'(DRIVE_LEN)) >> 3;
`else
  assign on_len = 32'(DRIVE_LEN);
`endif

  always_comb begin
    seg_d = 8'hFF;
    dig_d = 4'hF;
    fd_d  = 1'b0;
    if (state_d == DRIVE) begin
      dig_d = ~(4'b0001 << idx_d);
      if (32'(cnt_d) < on_len)
        seg_d = active_q[8*idx_d +: 8];
      fd_d = (idx_d == 2'd3) && (cnt_d == DRIVE_LAST);
    end
  end

  // active only moves at a frame boundary or while idle, so a frame is never torn.
  assign commit = pfull_q && (fd_q || (state_q == IDLE));
  assign accept = !pfull_q && load_valid;

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 32'hFFFF_FFFF;
      pending_q <= 32'hFFFF_FFFF;
      pfull_q   <= 1'b0;
    end else if (commit) begin
      active_q <= pending_q;
      pfull_q  <= 1'b0;
    end else if (accept) begin
      pending_q <= load_data;
      pfull_q   <= 1'b1;
    end
  end

  assign load_ready = !pfull_q;
  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed vector table, corner sequences and a
// randomized run checked against a timeline model of the scan.
module tb_seg_scan_driver;
  localparam int RD = 10;
  localparam int BC = 2;

  logic        clk_100mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'h0;
  logic        load_ready;
  logic [2:0]  brightness = 3'd7;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_done;

  int checks = 0;
  int fails  = 0;

  seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
`ifdef SEG_DIM_EN
    .brightness (brightness),
`endif
    .seg        (seg),
    .dig        (dig),
    .frame_done (frame_done)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Model: m_t counts cycles since the scan started; slot and position follow by division.
  logic        m_run  = 1'b0;
  int          m_t    = 0;
  logic [31:0] m_act  = 32'hFFFF_FFFF;
  logic [31:0] m_pend = 32'hFFFF_FFFF;
  logic        m_pfull = 1'b0;
  int          m_b    = 7;

  function automatic logic [3:0] exp_dig();
    logic [3:0] one;
    one = 4'b0001;
    if (!m_run || (m_t % RD) < BC) return 4'hF;
    return ~(one << ((m_t / RD) % 4));
  endfunction

  function automatic logic [7:0] exp_seg();
    int slot, pos;
    slot = (m_t / RD) % 4;
    pos  = m_t % RD;
    if (!m_run || pos < BC) return 8'hFF;
    if ((pos - BC) >= ((m_b + 1) * (RD - BC)) / 8) return 8'hFF;
    return m_act[slot*8 +: 8];
  endfunction

  function automatic logic exp_fd();
    return m_run && ((m_t / RD) % 4 == 3) && (m_t % RD == RD - 1);
  endfunction

  always @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      m_run   <= 1'b0;
      m_t     <= 0;
      m_act   <= 32'hFFFF_FFFF;
      m_pend  <= 32'hFFFF_FFFF;
      m_pfull <= 1'b0;
    end else begin
      if (m_pfull && (exp_fd() || !m_run)) begin
        m_act   <= m_pend;
        m_pfull <= 1'b0;
      end else if (!m_pfull && load_valid) begin
        m_pend  <= load_data;
        m_pfull <= 1'b1;
      end
      m_run <= enable;
      m_t   <= (m_run && enable) ? m_t + 1 : 0;
`ifdef SEG_DIM_EN
      m_b   <= int'(brightness);
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk_100mhz);
    chk("model_dig", 32'(dig), 32'(exp_dig()));
    chk("model_seg", 32'(seg), 32'(exp_seg()));
    chk("model_fd", 32'(frame_done), 32'(exp_fd()));
    chk("model_ready", 32'(load_ready), 32'(!m_pfull));
  endtask

  task automatic wait_dig(input logic [3:0] v, input string nm);
    int n;
    n = 0;
    while (dig !== v && n < 200) begin
      cyc();
      n++;
    end
    if (dig !== v) begin
      checks++;
      fails++;
      $display("FAIL %s timeout actual=%0h required=%0h", nm, dig, v);
    end
  endtask

  task automatic wait_fd(input string nm);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    if (frame_done !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL %s timeout actual=%0b required=1", nm, frame_done);
    end
  endtask

  typedef struct {
    int         t;
    logic [3:0] dig;
    logic [7:0] seg;
    logic       fd;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{0,  4'hF, 8'hFF, 1'b0};
    tbl[1]  = '{1,  4'hF, 8'hFF, 1'b0};
    tbl[2]  = '{2,  4'hE, 8'hF9, 1'b0};
    tbl[3]  = '{9,  4'hE, 8'hF9, 1'b0};
    tbl[4]  = '{10, 4'hF, 8'hFF, 1'b0};
    tbl[5]  = '{12, 4'hD, 8'hB0, 1'b0};
    tbl[6]  = '{19, 4'hD, 8'hB0, 1'b0};
    tbl[7]  = '{22, 4'hB, 8'h99, 1'b0};
    tbl[8]  = '{32, 4'h7, 8'h92, 1'b0};
    tbl[9]  = '{39, 4'h7, 8'h92, 1'b1};
    tbl[10] = '{40, 4'hF, 8'hFF, 1'b0};
    tbl[11] = '{42, 4'hE, 8'hF9, 1'b0};
    tbl[12] = '{79, 4'h7, 8'h92, 1'b1};

    repeat (3) cyc();
    chk("rst_dig", 32'(dig), 32'h F);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_ready", 32'(load_ready), 32'h1);
    rst_n = 1'b1;
    cyc();

    // Load while idle: accepted, then committed on the next idle clock.
    load_valid = 1'b1;
    load_data  = 32'h92_99_B0_F9;
    cyc();
    load_valid = 1'b0;
    chk("idle_ld_busy", 32'(load_ready), 32'h0);
    cyc();
    chk("idle_ld_ready", 32'(load_ready), 32'h1);

    enable = 1'b1;
    for (int t = 0; t < 80; t++) begin
      cyc();
      for (int k = 0; k < 13; k++) begin
        if (tbl[k].t == t) begin
          chk($sformatf("tbl%0d_dig", t), 32'(dig), 32'(tbl[k].dig));
          chk($sformatf("tbl%0d_seg", t), 32'(seg), 32'(tbl[k].seg));
          chk($sformatf("tbl%0d_fd", t), 32'(frame_done), 32'(tbl[k].fd));
        end
      end
    end

    // Mid-frame load, then a second offer while pending is full.
    repeat (5) cyc();
    load_valid = 1'b1;
    load_data  = 32'hC0C0_C0C0;
    cyc();
    load_valid = 1'b0;
    chk("mid_busy", 32'(load_ready), 32'h0);
    chk("mid_seg_old", 32'(seg), 32'hF9);
    load_valid = 1'b1;
    load_data  = 32'h1234_5678;
    repeat (3) cyc();
    load_valid = 1'b0;
    wait_fd("commit_fd");
    chk("commit_busy", 32'(load_ready), 32'h0);
    cyc();
    chk("commit_ready", 32'(load_ready), 32'h1);
    wait_dig(4'hE, "new_d0");
    chk("new_seg0", 32'(seg), 32'hC0);
    wait_dig(4'h7, "new_d3");
    chk("new_seg3", 32'(seg), 32'hC0);

    // Drop enable during digit 2.
    wait_dig(4'hB, "en_d2");
    enable = 1'b0;
    cyc();
    chk("dis_dig", 32'(dig), 32'hF);
    chk("dis_seg", 32'(seg), 32'hFF);
    repeat (3) cyc();
    enable = 1'b1;
    cyc();
    chk("reen_blank", 32'(dig), 32'hF);
    cyc();
    cyc();
    chk("reen_d0", 32'(dig), 32'hE);

    // Asynchronous reset during DRIVE with a frame pending.
    load_valid = 1'b1;
    load_data  = 32'hAAAA_AAAA;
    cyc();
    load_valid = 1'b0;
    wait_dig(4'hD, "rst_wait");
    chk("pre_rst_busy", 32'(load_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dig", 32'(dig), 32'hF);
    chk("async_seg", 32'(seg), 32'hFF);
    chk("async_ready", 32'(load_ready), 32'h1);
    enable = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_ready", 32'(load_ready), 32'h1);
    enable = 1'b1;
    wait_dig(4'hE, "post_rst_d0");
    chk("post_rst_seg", 32'(seg), 32'hFF);

`ifdef SEG_DIM_EN
    begin
      int lit;
      enable = 1'b0;
      cyc();
      load_valid = 1'b1;
      load_data  = 32'h8888_8888;
      cyc();
      load_valid = 1'b0;
      cyc();
      brightness = 3'd3;
      enable = 1'b1;
      wait_dig(4'hE, "dim_d0");
      lit = 0;
      for (int i = 0; i < RD - BC; i++) begin
        if (seg != 8'hFF) lit++;
        chk("dim_dig", 32'(dig), 32'hE);
        cyc();
      end
      chk("dim_lit", 32'(lit), 32'd4);
      brightness = 3'd7;
    end
`endif

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom_range(0, 99) < 96);
      load_valid = $urandom_range(0, 1) == 1;
      load_data  = $urandom;
`ifdef SEG_DIM_EN
      brightness = 3'($urandom_range(0, 7));
`endif
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 25000, clocks per digit slot (4 kHz slot rate, 1 kHz frame rate at 100 MHz); legal range 8..65535.
REQ-002 Parameter BLANK_CYCLES, default 100, dark clocks at the start of each slot (anti-ghosting); legal range 1..REFRESH_DIV-4.
REQ-003 clk_100mhz  input  1  system clock; all logic is clocked on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 enable  input  1  1 = scan the display, 0 = display dark.
REQ-006 load_valid  input  1  producer offers a new frame on load_data.
REQ-007 load_data  input  32  four active-low segment patterns; [7:0] = digit 0 ... [31:24] = digit 3; bit 7 of each byte = DP.
REQ-008 load_ready  output  1  block can accept a frame this cycle.
REQ-009 brightness  input  3  dimming level 0..7; present only when SEG_DIM_EN is defined.
REQ-010 seg  output  8  active-low segment drive, [6:0] = A..G, [7] = DP; registered.
REQ-011 dig  output  4  active-low digit select, one-hot-low while driving; registered.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each digit-3 slot.

Function
REQ-013 Behaviour is governed by three states: IDLE, BLANK and DRIVE.
REQ-014 IDLE: dig=4'hF, seg=8'hFF, digit index=0, slot counter=0; IDLE moves to BLANK on the first cycle with enable=1.
REQ-015 BLANK: dig=4'hF, seg=8'hFF for exactly BLANK_CYCLES clocks, then the block enters DRIVE.
REQ-016 DRIVE: dig bit[index]=0 (others 1), seg=active[index] for REFRESH_DIV-BLANK_CYCLES clocks, then index increments mod 4 (3 wraps to 0) and the block enters BLANK.
REQ-017 Each slot lasts exactly REFRESH_DIV clocks; a frame lasts 4*REFRESH_DIV clocks.
REQ-018 frame_done shall be 1 for exactly the clock in which DRIVE of index 3 ends; otherwise it is 0.
REQ-019 enable=0 in any state shall force IDLE on the next clock; outputs go dark in that same transition and there is no partial-slot completion.
REQ-020 Frame input uses two 32-bit registers: active (displayed) and pending (a one-entry buffer with a full flag).
REQ-021 load_ready = NOT pending_full (combinational from a register).
REQ-022 A frame is accepted when load_valid=1 and load_ready=1 on the same clock: load_data goes to pending and pending_full is set.
REQ-023 load_valid while load_ready=0 is ignored; the producer must hold the frame until it is accepted.
REQ-024 Commit: when pending_full=1, pending is copied to active and pending_full is cleared on the frame_done clock, or on any clock in IDLE.
REQ-025 On a commit clock, load_ready is still 0 and there is no simultaneous accept; load_ready rises on the next clock.
REQ-026 active never changes mid-frame while scanning, so no torn frames are visible.
REQ-027 dig and seg shall change only on state/index transitions (glitch-free, registered).

Reset
REQ-028 While rst_n=0 the following values shall hold: state=IDLE, index=0, counters=0, seg=8'hFF, dig=4'hF, frame_done=0, active=32'hFFFFFFFF, pending=32'hFFFFFFFF, pending_full=0 (load_ready=1).
REQ-029 Reset asserted mid-operation shall override all activity immediately; any pending frame is discarded.
REQ-030 After rst_n releases, the first scan begins on the first clock with enable=1.

Configuration
REQ-031 Macro SEG_DIM_EN: when defined, the brightness port exists; within DRIVE, seg=active[index] for the first floor((brightness+1)*(REFRESH_DIV-BLANK_CYCLES)/8) clocks and seg=8'hFF for the rest; dig and slot timing are unchanged.
REQ-032 When SEG_DIM_EN is defined, brightness=7 shall behave identically to SEG_DIM_EN undefined.
REQ-033 When SEG_DIM_EN is undefined, the brightness port is absent and seg is driven for the full DRIVE period.

Verification (bench uses REFRESH_DIV=10, BLANK_CYCLES=2)
REQ-034 Reset, then enable=1, load 32'h92_99_B0_F9 -> dig sequence 1110,1101,1011,0111 repeats; each digit is low for 8 clocks after 2 dark clocks; seg=F9,B0,99,92 respectively; frame_done pulses every 40 clocks.
REQ-035 A mid-frame load of 32'hC0C0C0C0 -> load_ready=0 the next clock; seg is unchanged until frame_done; the next frame shows C0 on all digits; load_ready=1 one clock after the commit.
REQ-036 A second load_valid while pending_full=1 -> it is ignored; the first queued frame is the one displayed.
REQ-037 enable dropped during DRIVE of index 2 -> next clock dig=F, seg=FF; on re-enable, scanning restarts at index 0 with BLANK.
REQ-038 rst_n pulsed low during DRIVE with a pending frame -> outputs go to FF/F asynchronously; after release active=FFFFFFFF and load_ready=1.
REQ-039 With SEG_DIM_EN defined and brightness=3 -> seg is active for 4 of 8 DRIVE clocks, then FF for 4; dig stays low all 8 clocks.
